// File: rtl/riscv_core_csr_pkg.sv
// riscv_core_csr_pkg
// Shared definitions for the machine-mode CSR/trap sequencer: FSM state type,
// SYSTEM opcode and funct3 encodings, fixed privileged instruction words and
// synchronous exception cause codes.
// No ports (package).

package riscv_core_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_WFI      = 2'd3
  } trap_state_e;

  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RSVD = 3'b100;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT    = 4'd3;
  localparam logic [3:0] EXC_ECALL_M       = 4'd11;

  // CSRRW/CSRRWI always write; the set/clear forms only write with a
  // non-zero rs1/uimm (the field sits in the same bits for both forms).
  function automatic logic csr_op_writes(input logic [2:0] f3, input logic [4:0] rs1);
    return (f3[1:0] == 2'b01) | (f3[1] & (rs1 != 5'd0));
  endfunction

endpackage

// File: rtl/riscv_core_csr_irq_prio_enc.sv
// riscv_core_csr_irq_prio_enc
// Priority encoder over the masked interrupt vector; the highest set index wins.
// Ports:
//   req  in   NUM_IRQ  pending & enabled interrupt lines
//   any  out  1        at least one line set
//   idx  out  IDX_W    index of the highest set line (0 when none)

module riscv_core_csr_irq_prio_enc
  import riscv_core_csr_pkg::*;
#(
  parameter int NUM_IRQ = 16,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  assign any = |req;

  // Ascending scan: later (higher) hits overwrite earlier ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/riscv_core_csr_trap_sequencer.sv
// riscv_core_csr_trap_sequencer
// Decodes SYSTEM instructions in execute and sequences M-mode trap entry,
// MRET return and WFI sleep; drives CSR-file write strobes and PC redirect.
// Optional feature macro: RISCV_CSR_VECTORED_EN (vectored interrupt targets
// when mtvec[1:0]==01; without it mtvec[1:0] is ignored).
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_valid, i_instr, i_pc         instruction in execute
//   i_mtvec, i_mepc, i_mstatus_mie CSR values
//   i_irq_pending, i_irq_enable    mip / mie bits
//   o_stall                        hold fetch/decode/execute (comb)
//   o_redirect, o_redirect_pc      1-cycle flush + PC load (registered)
//   o_mepc_wen/_wdata              1-cycle mepc write (registered)
//   o_mcause_wen/_wdata            1-cycle mcause write (registered)
//   o_mstatus_trap, o_mstatus_mret mstatus MIE/MPIE update pulses (registered)
//   o_csr_wen                      legal CSR op that writes (comb)
//   o_illegal                      illegal SYSTEM instruction (comb)
//
// state    | meaning
// ST_IDLE  | decode live instruction, launch trap / mret / wfi
// ST_SAVE  | mepc/mcause write + mstatus trap pulse, ignores inputs
// ST_REDIRECT | redirect pulse to trap vector or mepc, ignores inputs
// ST_WFI   | sleeping until an enabled interrupt is pending

module riscv_core_csr_trap_sequencer
  import riscv_core_csr_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_IRQ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [31:0]        i_instr,
  input  logic [XLEN-1:0]    i_pc,
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic [XLEN-1:0]    i_mepc,
  input  logic               i_mstatus_mie,
  input  logic [NUM_IRQ-1:0] i_irq_pending,
  input  logic [NUM_IRQ-1:0] i_irq_enable,
  output logic               o_stall,
  output logic               o_redirect,
  output logic [XLEN-1:0]    o_redirect_pc,
  output logic               o_mepc_wen,
  output logic [XLEN-1:0]    o_mepc_wdata,
  output logic               o_mcause_wen,
  output logic [XLEN-1:0]    o_mcause_wdata,
  output logic               o_mstatus_trap,
  output logic               o_mstatus_mret,
  output logic               o_csr_wen,
  output logic               o_illegal
);

  localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e state;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] cap_target;

  // Decode
  logic [2:0] f3;
  logic       is_system, is_ecall, is_ebreak, is_mret, is_wfi;
  logic       is_csr, csr_write, illegal_dec;

  assign f3        = i_instr[14:12];
  assign is_system = (i_instr[6:0] == OPC_SYSTEM);
  assign is_ecall  = (i_instr == INSTR_ECALL);
  assign is_ebreak = (i_instr == INSTR_EBREAK);
  assign is_mret   = (i_instr == INSTR_MRET);
  assign is_wfi    = (i_instr == INSTR_WFI);
  assign is_csr    = is_system & (f3 != F3_PRIV) & (f3 != F3_RSVD);
  assign csr_write = csr_op_writes(f3, i_instr[19:15]);

  // csr[11:10]==11 marks the read-only CSR space.
  assign illegal_dec = is_system &
                       (((f3 == F3_PRIV) & ~(is_ecall | is_ebreak | is_mret | is_wfi)) |
                        (f3 == F3_RSVD) |
                        (is_csr & csr_write & (i_instr[31:30] == 2'b11)));

  // Interrupts
  logic             irq_any;
  logic [IRQ_W-1:0] irq_idx;
  logic             irq_take;

  riscv_core_csr_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IRQ_W)
  ) u_irq_prio_enc (
    .req (i_irq_pending & i_irq_enable),
    .any (irq_any),
    .idx (irq_idx)
  );

  assign irq_take = i_mstatus_mie & irq_any;

  // Causes and targets
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_cause, irq_cause;
  logic [XLEN-1:0] vec_base, irq_target, pc_plus4;
  logic            trap_evt, idle;

  assign exc_code  = illegal_dec ? EXC_ILLEGAL_INSTR :
                     is_ebreak   ? EXC_BREAKPOINT    : EXC_ECALL_M;
  assign exc_cause = XLEN'(exc_code);
  assign irq_cause = {1'b1, (XLEN-1)'(irq_idx)};
  assign vec_base  = {i_mtvec[XLEN-1:2], 2'b00};
  assign pc_plus4  = i_pc + XLEN'(4);

`ifdef RISCV_CSR_VECTORED_EN
  assign irq_target = (i_mtvec[1:0] == 2'b01) ? vec_base + (XLEN'(irq_idx) << 2) : vec_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^i_mtvec[1:0];
  assign irq_target = vec_base;
`endif

  assign idle     = (state == ST_IDLE);
  assign trap_evt = irq_take | illegal_dec | is_ebreak | is_ecall;

  // Combinational outputs are held quiet while reset is asserted.
  assign o_illegal = i_rst_n & i_valid & illegal_dec;
  // An interrupt taken on this instruction means it does not retire.
  assign o_csr_wen = i_rst_n & idle & i_valid & is_csr & csr_write & ~illegal_dec & ~irq_take;
  // In WFI the stall drops on the wake cycle when interrupts are globally
  // off so the pipeline steps past the WFI instead of re-decoding it.
  assign o_stall   = i_rst_n &
                     ((idle & i_valid & (trap_evt | is_mret | is_wfi)) |
                      (state == ST_SAVE) |
                      ((state == ST_WFI) & ~(irq_any & ~i_mstatus_mie)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      cap_pc         <= '0;
      cap_target     <= '0;
      o_redirect     <= 1'b0;
      o_redirect_pc  <= '0;
      o_mepc_wen     <= 1'b0;
      o_mepc_wdata   <= '0;
      o_mcause_wen   <= 1'b0;
      o_mcause_wdata <= '0;
      o_mstatus_trap <= 1'b0;
      o_mstatus_mret <= 1'b0;
    end else begin
      o_redirect     <= 1'b0;
      o_mepc_wen     <= 1'b0;
      o_mcause_wen   <= 1'b0;
      o_mstatus_trap <= 1'b0;
      o_mstatus_mret <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            if (trap_evt) begin
              state          <= ST_SAVE;
              o_mepc_wen     <= 1'b1;
              o_mepc_wdata   <= i_pc;
              o_mcause_wen   <= 1'b1;
              o_mcause_wdata <= irq_take ? irq_cause : exc_cause;
              o_mstatus_trap <= 1'b1;
              cap_target     <= irq_take ? irq_target : vec_base;
            end else if (is_mret) begin
              state          <= ST_REDIRECT;
              o_redirect     <= 1'b1;
              o_redirect_pc  <= i_mepc;
              o_mstatus_mret <= 1'b1;
            end else if (is_wfi) begin
              state  <= ST_WFI;
              cap_pc <= pc_plus4;
            end
          end
        end
        ST_SAVE: begin
          state         <= ST_REDIRECT;
          o_redirect    <= 1'b1;
          o_redirect_pc <= cap_target;
        end
        ST_REDIRECT: begin
          state <= ST_IDLE;
        end
        ST_WFI: begin
          if (irq_any) begin
            if (i_mstatus_mie) begin
              state          <= ST_SAVE;
              o_mepc_wen     <= 1'b1;
              o_mepc_wdata   <= cap_pc;
              o_mcause_wen   <= 1'b1;
              o_mcause_wdata <= irq_cause;
              o_mstatus_trap <= 1'b1;
              cap_target     <= irq_target;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_csr_trap_sequencer.sv
// tb_riscv_core_csr_trap_sequencer
// Scoreboard bench: stimulus pushes expected output events (with the cycle
// they must appear in); a monitor pops and compares on every cycle where the
// DUT asserts any event output.

module tb_riscv_core_csr_trap_sequencer;

  localparam int XLEN    = 64;
  localparam int NUM_IRQ = 16;
`ifdef RISCV_CSR_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_valid;
  logic [31:0]        i_instr;
  logic [XLEN-1:0]    i_pc, i_mtvec, i_mepc;
  logic               i_mstatus_mie;
  logic [NUM_IRQ-1:0] i_irq_pending, i_irq_enable;
  logic               o_stall, o_redirect, o_mepc_wen, o_mcause_wen;
  logic               o_mstatus_trap, o_mstatus_mret, o_csr_wen, o_illegal;
  logic [XLEN-1:0]    o_redirect_pc, o_mepc_wdata, o_mcause_wdata;

  riscv_core_csr_trap_sequencer #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .i_instr        (i_instr),
    .i_pc           (i_pc),
    .i_mtvec        (i_mtvec),
    .i_mepc         (i_mepc),
    .i_mstatus_mie  (i_mstatus_mie),
    .i_irq_pending  (i_irq_pending),
    .i_irq_enable   (i_irq_enable),
    .o_stall        (o_stall),
    .o_redirect     (o_redirect),
    .o_redirect_pc  (o_redirect_pc),
    .o_mepc_wen     (o_mepc_wen),
    .o_mepc_wdata   (o_mepc_wdata),
    .o_mcause_wen   (o_mcause_wen),
    .o_mcause_wdata (o_mcause_wdata),
    .o_mstatus_trap (o_mstatus_trap),
    .o_mstatus_mret (o_mstatus_mret),
    .o_csr_wen      (o_csr_wen),
    .o_illegal      (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]     cyc;
    logic            illegal;
    logic            csr_wen;
    logic            mepc_wen;
    logic [XLEN-1:0] mepc;
    logic            mcause_wen;
    logic [XLEN-1:0] mcause;
    logic            trap;
    logic            redirect;
    logic [XLEN-1:0] rpc;
    logic            mret;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;

  localparam logic [63:0] IRQ_BIT = 64'h8000_0000_0000_0000;

  function automatic ev_t ev_comb(input int c, input logic ill, input logic wen);
    ev_t e = '0;
    e.cyc = c; e.illegal = ill; e.csr_wen = wen;
    return e;
  endfunction

  function automatic ev_t ev_save(input int c, input logic [63:0] pc, input logic [63:0] cause);
    ev_t e = '0;
    e.cyc = c; e.mepc_wen = 1'b1; e.mepc = pc; e.mcause_wen = 1'b1; e.mcause = cause;
    e.trap = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_redir(input int c, input logic [63:0] pc, input logic mret);
    ev_t e = '0;
    e.cyc = c; e.redirect = 1'b1; e.rpc = pc; e.mret = mret;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic monitor();
    ev_t obs, want;
    forever begin
      @(negedge i_clk);
      if (o_illegal | o_csr_wen | o_mepc_wen | o_mcause_wen | o_mstatus_trap |
          o_mstatus_mret | o_redirect) begin
        obs            = '0;
        obs.cyc        = cyc;
        obs.illegal    = o_illegal;
        obs.csr_wen    = o_csr_wen;
        obs.mepc_wen   = o_mepc_wen;
        obs.mepc       = o_mepc_wen ? o_mepc_wdata : '0;
        obs.mcause_wen = o_mcause_wen;
        obs.mcause     = o_mcause_wen ? o_mcause_wdata : '0;
        obs.trap       = o_mstatus_trap;
        obs.redirect   = o_redirect;
        obs.rpc        = o_redirect ? o_redirect_pc : '0;
        obs.mret       = o_mstatus_mret;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d ill=%b csr=%b mepc=%b/%h mcause=%b/%h trap=%b redir=%b/%h mret=%b",
                   cyc, obs.illegal, obs.csr_wen, obs.mepc_wen, obs.mepc, obs.mcause_wen,
                   obs.mcause, obs.trap, obs.redirect, obs.rpc, obs.mret);
        end else begin
          want = sb.pop_front();
          if (obs !== want) begin
            fails++;
            $display("FAIL event cyc=%0d got ill=%b csr=%b mepc=%b/%h mcause=%b/%h trap=%b redir=%b/%h mret=%b",
                     cyc, obs.illegal, obs.csr_wen, obs.mepc_wen, obs.mepc, obs.mcause_wen,
                     obs.mcause, obs.trap, obs.redirect, obs.rpc, obs.mret);
            $display("     expected cyc=%0d ill=%b csr=%b mepc=%b/%h mcause=%b/%h trap=%b redir=%b/%h mret=%b",
                     want.cyc, want.illegal, want.csr_wen, want.mepc_wen, want.mepc, want.mcause_wen,
                     want.mcause, want.trap, want.redirect, want.rpc, want.mret);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [63:0] pc, output int n);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_instr = instr; i_pc = pc;
    n = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_instr = '0;
    end
  endtask

  task automatic stimulus();
    int n, m;
    i_rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0;
    i_mtvec = 64'h8000_0000; i_mepc = '0; i_mstatus_mie = 1'b1;
    i_irq_pending = '0; i_irq_enable = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_stall", {63'd0, o_stall}, 64'd0);
    check("rst_redirect", {63'd0, o_redirect}, 64'd0);
    check("rst_mepc_wen", {63'd0, o_mepc_wen}, 64'd0);
    check("rst_mcause_wdata", o_mcause_wdata, 64'd0);
    i_rst_n = 1'b1;
    idle(2);

    // ECALL
    drive(32'h0000_0073, 64'h8000_0100, n);
    sb.push_back(ev_save(n + 1, 64'h8000_0100, 64'd11));
    sb.push_back(ev_redir(n + 2, 64'h8000_0000, 1'b0));
    #1 check("ecall_stall_n", {63'd0, o_stall}, 64'd1);
    idle(4);

    // MRET
    i_mepc = 64'h8000_0104;
    drive(32'h3020_0073, 64'h8000_0104, n);
    sb.push_back(ev_redir(n + 1, 64'h8000_0104, 1'b1));
    idle(3);

    // CSRRS x0, 0xF11, x0: read-only CSR read without write is legal
    drive(32'hF110_2073, 64'h8000_0108, n);
    @(negedge i_clk);
    check("csrrs_ro_nowrite_wen", {63'd0, o_csr_wen}, 64'd0);
    check("csrrs_ro_nowrite_illegal", {63'd0, o_illegal}, 64'd0);
    idle(2);

    // CSRRW x5, 0xF11, x1: write to read-only CSR
    drive(32'hF110_92F3, 64'h8000_0110, n);
    sb.push_back(ev_comb(n, 1'b1, 1'b0));
    sb.push_back(ev_save(n + 1, 64'h8000_0110, 64'd2));
    sb.push_back(ev_redir(n + 2, 64'h8000_0000, 1'b0));
    idle(4);

    // CSRRW x5, mscratch, x1 and CSRRS x5, mstatus, x1: legal writes
    drive(32'h3400_92F3, 64'h8000_0114, n);
    sb.push_back(ev_comb(n, 1'b0, 1'b1));
    drive(32'h3000_A2F3, 64'h8000_0118, n);
    sb.push_back(ev_comb(n, 1'b0, 1'b1));
    idle(2);

    // CSRRSI x5, 0xC00, 1: immediate write to read-only CSR
    drive(32'hC000_E2F3, 64'h8000_0120, n);
    sb.push_back(ev_comb(n, 1'b1, 1'b0));
    sb.push_back(ev_save(n + 1, 64'h8000_0120, 64'd2));
    sb.push_back(ev_redir(n + 2, 64'h8000_0000, 1'b0));
    idle(4);

    // EBREAK
    drive(32'h0010_0073, 64'h8000_0130, n);
    sb.push_back(ev_save(n + 1, 64'h8000_0130, 64'd3));
    sb.push_back(ev_redir(n + 2, 64'h8000_0000, 1'b0));
    idle(4);

    // funct3=100 reserved
    drive(32'h0000_4073, 64'h8000_0140, n);
    sb.push_back(ev_comb(n, 1'b1, 1'b0));
    sb.push_back(ev_save(n + 1, 64'h8000_0140, 64'd2));
    sb.push_back(ev_redir(n + 2, 64'h8000_0000, 1'b0));
    idle(4);

    // Non-SYSTEM instruction: no action
    drive(32'h0000_0013, 64'h8000_0144, n);
    @(negedge i_clk);
    check("addi_stall", {63'd0, o_stall}, 64'd0);
    idle(3);

    // Pending IRQ with mstatus.MIE=0: ECALL still takes the exception
    i_mstatus_mie = 1'b0;
    i_irq_pending = 16'h0020; i_irq_enable = 16'h0020;
    drive(32'h0000_0073, 64'h8000_0150, n);
    sb.push_back(ev_save(n + 1, 64'h8000_0150, 64'd11));
    sb.push_back(ev_redir(n + 2, 64'h8000_0000, 1'b0));
    idle(1);
    i_irq_pending = '0; i_irq_enable = '0; i_mstatus_mie = 1'b1;
    idle(3);

    // IRQ3 + IRQ11 with ECALL: interrupt wins, highest index wins
    i_mtvec = 64'h8000_0001;
    i_irq_pending = 16'h0808; i_irq_enable = 16'h0808;
    drive(32'h0000_0073, 64'h8000_0160, n);
    sb.push_back(ev_save(n + 1, 64'h8000_0160, IRQ_BIT | 64'd11));
    sb.push_back(ev_redir(n + 2, VEC ? 64'h8000_002C : 64'h8000_0000, 1'b0));
    idle(1);
    i_irq_pending = '0;
    idle(3);

    // IRQ4 on a CSR write: write suppressed, interrupt taken
    i_irq_pending = 16'h0010; i_irq_enable = 16'h0010;
    drive(32'h3400_92F3, 64'h8000_0170, n);
    sb.push_back(ev_save(n + 1, 64'h8000_0170, IRQ_BIT | 64'd4));
    sb.push_back(ev_redir(n + 2, VEC ? 64'h8000_0010 : 64'h8000_0000, 1'b0));
    idle(1);
    i_irq_pending = '0;
    idle(3);

    // WFI, MIE=1, IRQ7 arrives 5 cycles later
    i_irq_enable = 16'h0080;
    drive(32'h1050_0073, 64'h8000_0200, n);
    idle(1);
    @(negedge i_clk);
    check("wfi_sleep_stall", {63'd0, o_stall}, 64'd1);
    repeat (3) @(posedge i_clk);
    @(posedge i_clk); #1;
    i_irq_pending = 16'h0080;
    m = cyc;
    check("wfi_wake_delay", 64'(m - n), 64'd5);
    sb.push_back(ev_save(m + 1, 64'h8000_0204, IRQ_BIT | 64'd7));
    sb.push_back(ev_redir(m + 2, VEC ? 64'h8000_001C : 64'h8000_0000, 1'b0));
    idle(1);
    i_irq_pending = '0;
    idle(4);

    // WFI, MIE=0: wake drops the stall, no trap
    i_mstatus_mie = 1'b0; i_mtvec = 64'h8000_0000;
    i_irq_enable = 16'h0004;
    drive(32'h1050_0073, 64'h8000_0300, n);
    idle(1);
    @(negedge i_clk);
    check("wfi_nomie_sleep_stall", {63'd0, o_stall}, 64'd1);
    @(posedge i_clk); #1;
    i_irq_pending = 16'h0004;
    @(negedge i_clk);
    check("wfi_nomie_wake_stall", {63'd0, o_stall}, 64'd0);
    @(posedge i_clk); #1;
    i_irq_pending = '0;
    @(negedge i_clk);
    check("wfi_nomie_idle_stall", {63'd0, o_stall}, 64'd0);
    idle(2);
    i_mstatus_mie = 1'b1; i_irq_enable = '0;

    // Reset while in SAVE aborts the sequence
    drive(32'h0000_0073, 64'h8000_0400, n);
    idle(1);
    i_rst_n = 1'b0;
    #1;
    check("rstsave_mepc_wen", {63'd0, o_mepc_wen}, 64'd0);
    check("rstsave_mcause_wen", {63'd0, o_mcause_wen}, 64'd0);
    check("rstsave_trap", {63'd0, o_mstatus_trap}, 64'd0);
    check("rstsave_stall", {63'd0, o_stall}, 64'd0);
    check("rstsave_mepc_wdata", o_mepc_wdata, 64'd0);
    idle(2);
    i_rst_n = 1'b1;
    idle(5);
    check("rstsave_after_redirect", {63'd0, o_redirect}, 64'd0);
    check("rstsave_after_stall", {63'd0, o_stall}, 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout, expected bench completion");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
